complex_mult_acc: RTL and testbench

//  Parametrised, pipelined signed complex multiply-accumulate with valid/ready streaming.

---
 rtl/complex_mult_pkg.sv | 44 ++++
 rtl/complex_mult_core.sv | 109 ++++++++++
 rtl/complex_mult_acc.sv | 121 ++++++++++++
 tb/tb_complex_mult_acc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_mult_pkg.sv
// rtl/complex_mult_pkg.sv - shared widths, component slicing and saturating add
package complex_mult_pkg;

    localparam int IM_IDX = 0;
    localparam int RE_IDX = 1;
    localparam int SAT_W  = 64;

    typedef struct packed {
        logic                    sat;
        logic signed [SAT_W-1:0] val;
    } sat_res_t;

    function automatic int acc_w(input int data_w, input int guard_w);
        return 2 * data_w + 1 + guard_w;
    endfunction

    // Operands arrive sign-extended to SAT_W; the result is clamped to a w-bit signed range.
    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                         input logic signed [SAT_W-1:0] b,
                                         input int                      w);
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] one;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sat_res_t              r;
        one    = '0;
        one[0] = 1'b1;
        sum    = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi     = (one <<< (w - 1)) - one;
        lo     = -hi - one;
        if (sum > hi) begin
            r.val = hi[SAT_W-1:0];
            r.sat = 1'b1;
        end else if (sum < lo) begin
            r.val = lo[SAT_W-1:0];
            r.sat = 1'b1;
        end else begin
            r.val = sum[SAT_W-1:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/complex_mult_core.sv
// rtl/complex_mult_core.sv - three-stage complex multiplier with frame tag pass-through
module complex_mult_core
    import complex_mult_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [2*DATA_W-1:0]   in_a,
    input  logic [2*DATA_W-1:0]   in_b,
    input  logic                  in_conj,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic signed [2*DATA_W:0] out_re,
    output logic signed [2*DATA_W:0] out_im,
    output logic                  out_first,
    output logic                  out_last
);

    localparam int PW = 2 * DATA_W;
    localparam int SW = PW + 1;

    logic              s1_valid_q, s1_valid_d, s1_conj_q, s1_conj_d;
    logic              s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic [PW-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;

    logic              s2_valid_q, s2_valid_d, s2_conj_q, s2_conj_d;
    logic              s2_first_q, s2_first_d, s2_last_q, s2_last_d;
    logic signed [PW-1:0] s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d;
    logic signed [PW-1:0] s2_ir_q, s2_ir_d, s2_ri_q, s2_ri_d;

    logic              s3_valid_q, s3_valid_d, s3_first_q, s3_first_d, s3_last_q, s3_last_d;
    logic signed [SW-1:0] s3_re_q, s3_re_d, s3_im_q, s3_im_d;

    logic signed [DATA_W-1:0] ar, ai, br, bi;
    logic signed [PW-1:0]     ar_x, ai_x, br_x, bi_x;
    logic signed [SW-1:0]     rr_x, ii_x, ir_x, ri_x;

    assign ar   = s1_a_q[RE_IDX*DATA_W +: DATA_W];
    assign ai   = s1_a_q[IM_IDX*DATA_W +: DATA_W];
    assign br   = s1_b_q[RE_IDX*DATA_W +: DATA_W];
    assign bi   = s1_b_q[IM_IDX*DATA_W +: DATA_W];
    assign ar_x = {{DATA_W{ar[DATA_W-1]}}, ar};
    assign ai_x = {{DATA_W{ai[DATA_W-1]}}, ai};
    assign br_x = {{DATA_W{br[DATA_W-1]}}, br};
    assign bi_x = {{DATA_W{bi[DATA_W-1]}}, bi};
    assign rr_x = {s2_rr_q[PW-1], s2_rr_q};
    assign ii_x = {s2_ii_q[PW-1], s2_ii_q};
    assign ir_x = {s2_ir_q[PW-1], s2_ir_q};
    assign ri_x = {s2_ri_q[PW-1], s2_ri_q};

    always_comb begin
        s1_valid_d = s1_valid_q; s1_conj_d = s1_conj_q;
        s1_first_d = s1_first_q; s1_last_d = s1_last_q;
        s1_a_d     = s1_a_q;     s1_b_d    = s1_b_q;
        s2_valid_d = s2_valid_q; s2_conj_d = s2_conj_q;
        s2_first_d = s2_first_q; s2_last_d = s2_last_q;
        s2_rr_d    = s2_rr_q;    s2_ii_d   = s2_ii_q;
        s2_ir_d    = s2_ir_q;    s2_ri_d   = s2_ri_q;
        s3_valid_d = s3_valid_q; s3_first_d = s3_first_q; s3_last_d = s3_last_q;
        s3_re_d    = s3_re_q;    s3_im_d   = s3_im_q;
        if (en) begin
            s1_valid_d = in_valid; s1_conj_d = in_conj;
            s1_first_d = in_first; s1_last_d = in_last;
            s1_a_d     = in_a;     s1_b_d    = in_b;
            // Products fit exactly in PW bits, including (-2**(W-1))**2.
            s2_valid_d = s1_valid_q; s2_conj_d = s1_conj_q;
            s2_first_d = s1_first_q; s2_last_d = s1_last_q;
            s2_rr_d    = ar_x * br_x;
            s2_ii_d    = ai_x * bi_x;
            s2_ir_d    = ai_x * br_x;
            s2_ri_d    = ar_x * bi_x;
            s3_valid_d = s2_valid_q; s3_first_d = s2_first_q; s3_last_d = s2_last_q;
            s3_re_d    = s2_conj_q ? rr_x + ii_x : rr_x - ii_x;
            s3_im_d    = s2_conj_q ? ir_x - ri_x : ir_x + ri_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0; s1_conj_q <= 1'b0; s1_first_q <= 1'b0; s1_last_q <= 1'b0;
            s1_a_q     <= '0;   s1_b_q    <= '0;
            s2_valid_q <= 1'b0; s2_conj_q <= 1'b0; s2_first_q <= 1'b0; s2_last_q <= 1'b0;
            s2_rr_q    <= '0;   s2_ii_q   <= '0;   s2_ir_q    <= '0;   s2_ri_q   <= '0;
            s3_valid_q <= 1'b0; s3_first_q <= 1'b0; s3_last_q <= 1'b0;
            s3_re_q    <= '0;   s3_im_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d; s1_conj_q <= s1_conj_d;
            s1_first_q <= s1_first_d; s1_last_q <= s1_last_d;
            s1_a_q     <= s1_a_d;     s1_b_q    <= s1_b_d;
            s2_valid_q <= s2_valid_d; s2_conj_q <= s2_conj_d;
            s2_first_q <= s2_first_d; s2_last_q <= s2_last_d;
            s2_rr_q    <= s2_rr_d;    s2_ii_q   <= s2_ii_d;
            s2_ir_q    <= s2_ir_d;    s2_ri_q   <= s2_ri_d;
            s3_valid_q <= s3_valid_d; s3_first_q <= s3_first_d; s3_last_q <= s3_last_d;
            s3_re_q    <= s3_re_d;    s3_im_q   <= s3_im_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign out_re    = s3_re_q;
    assign out_im    = s3_im_q;
    assign out_first = s3_first_q;
    assign out_last  = s3_last_q;

endmodule

// File: rtl/complex_mult_acc.sv
// rtl/complex_mult_acc.sv - framed complex multiply-accumulate with valid/ready streaming
module complex_mult_acc
    import complex_mult_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int ACC_LEN_W = 4,
    parameter  int GUARD_W   = 4,
    localparam int ACC_W     = acc_w(DATA_W, GUARD_W)
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [2*DATA_W-1:0]   InA,
    input  logic [2*DATA_W-1:0]   InB,
    input  logic                  Conj,
    input  logic [ACC_LEN_W-1:0]  AccLen,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [2*ACC_W-1:0]    OutData,
    output logic                  OutSat
);

    localparam int SW = 2 * DATA_W + 1;

    logic                  en, accept, frame_first, frame_last;
    logic [ACC_LEN_W-1:0]  count_q, count_d, len_q, len_d, eff_len;
    logic                  s3_valid, s3_first, s3_last;
    logic signed [SW-1:0]  s3_re, s3_im;
    logic signed [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic                  sat_q, sat_d, out_valid_q, out_valid_d, out_sat_q, out_sat_d;
    logic [2*ACC_W-1:0]    out_data_q, out_data_d;
    sat_res_t              r_re, r_im;

    // The whole pipeline freezes while a finished frame waits for the consumer.
    assign en      = !out_valid_q || OutReady;
    assign InReady = en && ResetN;
    assign accept  = InValid && InReady;

    assign frame_first = (count_q == '0);
    assign eff_len     = frame_first ? AccLen : len_q;
    assign frame_last  = (count_q == eff_len);

    complex_mult_core #(.DATA_W(DATA_W)) u_core (
        .clk       (Clk),
        .rst_n     (ResetN),
        .en        (en),
        .in_valid  (accept),
        .in_a      (InA),
        .in_b      (InB),
        .in_conj   (Conj),
        .in_first  (frame_first),
        .in_last   (frame_last),
        .out_valid (s3_valid),
        .out_re    (s3_re),
        .out_im    (s3_im),
        .out_first (s3_first),
        .out_last  (s3_last)
    );

    function automatic sat_res_t acc_step(input logic signed [ACC_W-1:0] base,
                                          input logic signed [SW-1:0]    p);
        return sat_add({{(SAT_W-ACC_W){base[ACC_W-1]}}, base},
                       {{(SAT_W-SW){p[SW-1]}}, p}, ACC_W);
    endfunction

    always_comb begin
        count_d     = count_q;
        len_d       = len_q;
        acc_re_d    = acc_re_q;
        acc_im_d    = acc_im_q;
        sat_d       = sat_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q && !OutReady;
        if (accept) begin
            if (frame_first) len_d = AccLen;
            count_d = frame_last ? '0 : count_q + 1'b1;
        end
        // A first-tagged product restarts the sum from zero, so stale state never leaks across frames.
        r_re = acc_step(s3_first ? '0 : acc_re_q, s3_re);
        r_im = acc_step(s3_first ? '0 : acc_im_q, s3_im);
        if (en && s3_valid) begin
            acc_re_d = r_re.val[ACC_W-1:0];
            acc_im_d = r_im.val[ACC_W-1:0];
            sat_d    = (!s3_first && sat_q) || r_re.sat || r_im.sat;
            if (s3_last) begin
                out_data_d  = {acc_re_d, acc_im_d};
                out_sat_d   = sat_d;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            count_q     <= '0;
            len_q       <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            len_q       <= len_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign OutValid = out_valid_q;
    assign OutData  = out_data_q;
    assign OutSat   = out_sat_q;

endmodule

// File: tb/tb_complex_mult_acc.sv
// tb/tb_complex_mult_acc.sv - directed self-checking bench for complex_mult_acc
module tb_complex_mult_acc;

    localparam int ACC_W  = 21;
    localparam int ACC1_W = 17;

    logic              Clk = 1'b0;
    logic              ResetN = 1'b0;
    logic              InValid = 1'b0;
    logic              Conj = 1'b0;
    logic              OutReady = 1'b1;
    logic [15:0]       InA = '0;
    logic [15:0]       InB = '0;
    logic [3:0]        AccLen = '0;
    logic              InReady, OutValid, OutSat;
    logic [2*ACC_W-1:0] OutData;
    logic              InReady1, OutValid1, OutSat1;
    logic [2*ACC1_W-1:0] OutData1;

    int n_checks = 0;
    int n_pass   = 0;
    int out_xfers = 0;

    always #5 Clk = ~Clk;

    complex_mult_acc dut (
        .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
        .InA(InA), .InB(InB), .Conj(Conj), .AccLen(AccLen),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutSat(OutSat)
    );

    complex_mult_acc #(.GUARD_W(0)) dut_sat (
        .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady1),
        .InA(InA), .InB(InB), .Conj(Conj), .AccLen(AccLen),
        .OutValid(OutValid1), .OutReady(OutReady), .OutData(OutData1), .OutSat(OutSat1)
    );

    always @(posedge Clk) if (OutValid && OutReady) out_xfers++;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic signed [63:0] sx(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = v << (64 - w);
        return t >>> (64 - w);
    endfunction

    function automatic logic signed [63:0] out_re();
        return sx(64'(OutData[2*ACC_W-1:ACC_W]), ACC_W);
    endfunction

    function automatic logic signed [63:0] out_im();
        return sx(64'(OutData[ACC_W-1:0]), ACC_W);
    endfunction

    task automatic set_in(input int ar, input int ai, input int br, input int bi,
                          input logic cj, input int len);
        InA    = {8'(ar), 8'(ai)};
        InB    = {8'(br), 8'(bi)};
        Conj   = cj;
        AccLen = 4'(len);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input logic cj, input int len);
        int g;
        set_in(ar, ai, br, bi, cj, len);
        InValid = 1'b1;
        g = 0;
        while (!InReady && g < 50) begin
            @(negedge Clk);
            g++;
        end
        if (g == 50) check("send_timeout", InReady, 1);
        @(posedge Clk);
        @(negedge Clk);
        InValid = 1'b0;
    endtask

    task automatic get_out(input string tag, input longint e_re, input longint e_im, input logic e_sat);
        int g;
        g = 0;
        while (!OutValid && g < 50) begin
            @(negedge Clk);
            g++;
        end
        check({tag, "_valid"}, OutValid, 1);
        check({tag, "_re"}, out_re(), e_re);
        check({tag, "_im"}, out_im(), e_im);
        check({tag, "_sat"}, OutSat, e_sat);
    endtask

    initial begin
        int xb, idx, got, g;
        logic stalled_prev;
        logic [2*ACC_W-1:0] held;
        longint e_re, e_im, ar, ai, br, bi;

        // Reset state
        @(negedge Clk);
        check("rst_outvalid", OutValid, 0);
        check("rst_outdata", OutData, 0);
        check("rst_outsat", OutSat, 0);
        check("rst_inready", InReady, 0);
        ResetN = 1'b1;
        @(negedge Clk);

        // 1: plain multiply and latency
        set_in(3, 4, 5, -2, 1'b0, 0);
        InValid = 1'b1;
        check("t1_inready", InReady, 1);
        @(posedge Clk);
        @(negedge Clk);
        InValid = 1'b0;
        check("t1_lat_t0", OutValid, 0);
        @(negedge Clk);
        check("t1_lat_t1", OutValid, 0);
        @(negedge Clk);
        check("t1_lat_t2", OutValid, 0);
        @(negedge Clk);
        check("t1_lat_t3", OutValid, 1);
        check("t1_re", out_re(), 23);
        check("t1_im", out_im(), 14);
        check("t1_sat", OutSat, 0);
        @(negedge Clk);

        // 2: -128 corner, both conjugation modes
        send(-128, -128, -128, -128, 1'b0, 0);
        get_out("t2_noconj", 0, 32768, 1'b0);
        @(negedge Clk);
        send(-128, -128, -128, -128, 1'b1, 0);
        get_out("t2_conj", 32768, 0, 1'b0);
        @(negedge Clk);

        // 3: four-product frame; AccLen changes after the first sample are ignored
        xb = out_xfers;
        send(1, 1, 2, 0, 1'b0, 3);
        send(1, 1, 2, 0, 1'b0, 0);
        send(1, 1, 2, 0, 1'b0, 0);
        repeat (5) @(negedge Clk);
        check("t3_no_early_out", out_xfers, xb);
        send(1, 1, 2, 0, 1'b0, 0);
        get_out("t3_acc", 8, 8, 1'b0);
        @(negedge Clk);
        check("t3_one_out", out_xfers, xb + 1);
        send(1, 1, 2, 0, 1'b0, 0);
        get_out("t3_fresh", 2, 2, 1'b0);
        @(negedge Clk);

        // 4: 16-product frame; exact with 4 guard bits, clamps with none
        for (int i = 0; i < 16; i++) send(-128, -128, -128, -128, 1'b0, 15);
        get_out("t4_exact", 0, 524288, 1'b0);
        check("t4g0_valid", OutValid1, 1);
        check("t4g0_re", sx(64'(OutData1[2*ACC1_W-1:ACC1_W]), ACC1_W), 0);
        check("t4g0_im", sx(64'(OutData1[ACC1_W-1:0]), ACC1_W), 65535);
        check("t4g0_sat", OutSat1, 1);
        @(negedge Clk);

        // 5: streaming with random backpressure
        xb = out_xfers;
        idx = 0;
        got = 0;
        stalled_prev = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
            @(negedge Clk);
            if (stalled_prev && OutValid) check("t5_stall_hold", OutData, held);
            InValid = (idx < 20);
            set_in(idx - 10, 2 * idx - 7, 3, -idx, idx[0], 0);
            OutReady = 1'($urandom_range(0, 1));
            #1;
            if (OutValid && !OutReady) check("t5_stall_inready", InReady, 0);
            if (OutValid && OutReady) begin
                ar = got - 10; ai = 2 * got - 7; br = 3; bi = -got;
                e_re = got[0] ? ar * br + ai * bi : ar * br - ai * bi;
                e_im = got[0] ? ai * br - ar * bi : ai * br + ar * bi;
                check($sformatf("t5_re%0d", got), out_re(), e_re);
                check($sformatf("t5_im%0d", got), out_im(), e_im);
                got++;
            end
            stalled_prev = OutValid && !OutReady;
            held = OutData;
            if (InValid && InReady) idx++;
        end
        @(negedge Clk);
        InValid  = 1'b0;
        OutReady = 1'b1;
        repeat (6) @(negedge Clk);
        check("t5_results", got, 20);
        check("t5_xfers", out_xfers - xb, 20);

        // 6a: async reset clears a stalled result without a clock edge
        OutReady = 1'b0;
        send(3, 4, 5, -2, 1'b0, 0);
        g = 0;
        while (!OutValid && g < 20) begin
            @(negedge Clk);
            g++;
        end
        check("t6_stalled", OutValid, 1);
        #2 ResetN = 1'b0;
        #1;
        check("t6_rst_valid", OutValid, 0);
        check("t6_rst_data", OutData, 0);
        check("t6_rst_sat", OutSat, 0);
        check("t6_rst_inready", InReady, 0);
        @(negedge Clk);
        ResetN   = 1'b1;
        OutReady = 1'b1;
        @(negedge Clk);

        // 6b: reset discards a partial frame
        send(1, 1, 2, 0, 1'b0, 3);
        send(1, 1, 2, 0, 1'b0, 3);
        repeat (3) @(negedge Clk);
        #2 ResetN = 1'b0;
        #1;
        check("t6b_rst_inready", InReady, 0);
        @(negedge Clk);
        ResetN = 1'b1;
        @(negedge Clk);
        send(3, 4, 5, -2, 1'b0, 0);
        get_out("t6b_after", 23, 14, 1'b0);
        @(negedge Clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
